// File: rtl/i2c_eeprom_slave.sv
// I2C slave emulating a 24xx-style EEPROM (MEM_BYTES x 8, 1-byte word address) on oversampled open-drain lines.
// SDA updates ~3 clk after each synchronized SCL fall; never stretches SCL, so the master alone paces the bus.
module i2c_eeprom_slave #(
    parameter logic [6:0] ADDRESS   = 7'b1010000,
    parameter int         MEM_BYTES = 256,
    parameter int         PAGE_SIZE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_oe_o,
    output logic busy_o
);
    localparam int AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    localparam logic [3:0] IDLE       = 4'd0;
    localparam logic [3:0] DEV_ADDR   = 4'd1;
    localparam logic [3:0] ACK_DEV    = 4'd2;
    localparam logic [3:0] WORD_ADDR  = 4'd3;
    localparam logic [3:0] ACK_WORD   = 4'd4;
    localparam logic [3:0] WRITE_DATA = 4'd5;
    localparam logic [3:0] ACK_WRITE  = 4'd6;
    localparam logic [3:0] READ_DATA  = 4'd7;
    localparam logic [3:0] READ_ACK   = 4'd8;

    logic          scl_s1, scl_s2, scl_d;
    logic          sda_s1, sda_s2, sda_d;
    logic          scl_rise, scl_fall, scl_hi, start_det, stop_det;
    logic [3:0]    state;
    logic [3:0]    bit_cnt;
    logic [7:0]    rx_sh, tx_sh;
    logic [AW-1:0] ptr, ptr_page_inc;
    logic [7:0]    rx_byte, rd_byte;
    logic          wr_en;
    logic [7:0]    mem [MEM_BYTES];

    // Synchronizers idle high so leaving reset never looks like a bus edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {scl_s1, scl_s2, scl_d} <= 3'b111;
            {sda_s1, sda_s2, sda_d} <= 3'b111;
        end else begin
            scl_s1 <= scl_i;
            scl_s2 <= scl_s1;
            scl_d  <= scl_s2;
            sda_s1 <= sda_i;
            sda_s2 <= sda_s1;
            sda_d  <= sda_s2;
        end
    end

    assign scl_rise  = scl_s2 & ~scl_d;
    assign scl_fall  = ~scl_s2 & scl_d;
    assign scl_hi    = scl_s2 & scl_d;
    assign start_det = scl_hi & ~sda_s2 & sda_d;
    assign stop_det  = scl_hi & sda_s2 & ~sda_d;

    assign rx_byte      = {rx_sh[6:0], sda_s2};
    assign rd_byte      = mem[ptr];
    assign ptr_page_inc = (ptr & ~PAGE_MASK) | ((ptr + PTR_ONE) & PAGE_MASK);
    assign wr_en        = (state == WRITE_DATA) && scl_rise && (bit_cnt == 4'd7);

    always_ff @(posedge clk) begin
        if (wr_en) mem[ptr] <= rx_byte;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            rx_sh    <= '0;
            tx_sh    <= '0;
            ptr      <= '0;
            sda_oe_o <= 1'b0;
            busy_o   <= 1'b0;
        end else if (start_det) begin
            state    <= DEV_ADDR;
            bit_cnt  <= '0;
            sda_oe_o <= 1'b0;
        end else if (stop_det) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            sda_oe_o <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                DEV_ADDR: if (scl_rise) begin
                    rx_sh   <= rx_byte;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        if (rx_byte[7:1] == ADDRESS) begin
                            state  <= ACK_DEV;
                            busy_o <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                end
                WORD_ADDR: if (scl_rise) begin
                    rx_sh   <= rx_byte;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) begin
                        ptr   <= rx_byte[AW-1:0];
                        state <= ACK_WORD;
                    end
                end
                WRITE_DATA: if (scl_rise) begin
                    rx_sh   <= rx_byte;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd7) state <= ACK_WRITE;
                end
                // bit_cnt 8: waiting for the fall that opens the ACK slot; 9: ACK clock seen.
                ACK_DEV, ACK_WORD, ACK_WRITE: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe_o <= 1'b1;
                    end else if (scl_rise) begin
                        bit_cnt <= 4'd9;
                        if (state == ACK_WRITE) ptr <= ptr_page_inc;
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        bit_cnt <= '0;
                        if (state == ACK_DEV && rx_sh[0]) begin
                            state    <= READ_DATA;
                            tx_sh    <= rd_byte;
                            sda_oe_o <= ~rd_byte[7];
                        end else begin
                            sda_oe_o <= 1'b0;
                            state    <= (state == ACK_DEV) ? WORD_ADDR : WRITE_DATA;
                        end
                    end
                end
                READ_DATA: begin
                    if (scl_rise) begin
                        tx_sh   <= {tx_sh[6:0], 1'b0};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd7) state <= READ_ACK;
                    end else if (scl_fall) begin
                        sda_oe_o <= ~tx_sh[7];
                    end
                end
                READ_ACK: begin
                    if (scl_fall && bit_cnt == 4'd8) begin
                        sda_oe_o <= 1'b0;
                    end else if (scl_rise) begin
                        ptr     <= ptr + PTR_ONE;
                        bit_cnt <= 4'd9;
                        if (sda_s2) begin
                            state   <= IDLE;
                            busy_o  <= 1'b0;
                            bit_cnt <= '0;
                        end
                    end else if (scl_fall && bit_cnt == 4'd9) begin
                        state    <= READ_DATA;
                        bit_cnt  <= '0;
                        tx_sh    <= rd_byte;
                        sda_oe_o <= ~rd_byte[7];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: a bit-banged I2C master queues expected ACK bits, read bytes and status levels;
// a single monitor process pops and compares them as the slave answers on the bus.
module tb_i2c_eeprom_slave;
    localparam int   Q        = 10;
    localparam logic SEL_OE   = 1'b0;
    localparam logic SEL_BUSY = 1'b1;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_oe, busy, sda_bus;

    assign sda_bus = sda_m & ~sda_oe;
    always #5 clk = ~clk;

    i2c_eeprom_slave #(.ADDRESS(7'b1010000), .MEM_BYTES(256), .PAGE_SIZE(16)) dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus),
        .sda_oe_o(sda_oe), .busy_o(busy)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    string      exp_nm[$];
    logic [7:0] exp_val[$];
    int         exp_nb[$];
    string      st_nm[$];
    logic       st_sel[$];
    logic       st_want[$];
    logic       slot    = 1'b0;
    logic       chk_tgl = 1'b0;
    logic       done    = 1'b0;

    logic       last_tgl = 1'b0;
    logic [7:0] mon_sh   = 8'd0;
    int         mon_cnt  = 0;
    logic [7:0] got8, want8;
    logic       got1, want1, sel1;
    string      nm;

    initial begin
        forever begin
            @(posedge scl_m or chk_tgl);
            if (chk_tgl != last_tgl) begin
                last_tgl = chk_tgl;
                while (st_nm.size() > 0) begin
                    nm    = st_nm.pop_front();
                    sel1  = st_sel.pop_front();
                    want1 = st_want.pop_front();
                    got1  = sel1 ? busy : sda_oe;
                    n_tests++;
                    if (got1 !== want1) begin
                        n_fail++;
                        $display("FAIL %s: got %b required %b", nm, got1, want1);
                    end
                end
                if (done) begin
                    n_tests++;
                    if (exp_nb.size() != 0) begin
                        n_fail++;
                        $display("FAIL leftover: %0d responses never seen, required 0", exp_nb.size());
                    end
                end
            end else if (slot) begin
                mon_sh = {mon_sh[6:0], sda_bus};
                mon_cnt++;
                if (exp_nb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_slot: sda=%b with nothing expected", sda_bus);
                    mon_cnt = 0;
                end else if (mon_cnt == exp_nb[0]) begin
                    got8  = (exp_nb[0] == 1) ? {7'd0, mon_sh[0]} : mon_sh;
                    want8 = exp_val.pop_front();
                    nm    = exp_nm.pop_front();
                    void'(exp_nb.pop_front());
                    mon_cnt = 0;
                    n_tests++;
                    if (got8 !== want8) begin
                        n_fail++;
                        $display("FAIL %s: got 0x%02h required 0x%02h", nm, got8, want8);
                    end
                end
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic sel, input logic want);
        st_nm.push_back(name);
        st_sel.push_back(sel);
        st_want.push_back(want);
        chk_tgl = ~chk_tgl;
        #1;
    endtask

    task automatic bit_out(input logic b);
        wait_clk(Q); sda_m = b;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(2 * Q); scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q); sda_m = 1'b0;
        wait_clk(Q); scl_m = 1'b1;
        wait_clk(Q); sda_m = 1'b1;
        wait_clk(2 * Q);
    endtask

    task automatic write_byte(input string name, input logic [7:0] b, input logic ack);
        for (int i = 7; i >= 0; i--) bit_out(b[i]);
        exp_nm.push_back(name); exp_val.push_back({7'd0, ack}); exp_nb.push_back(1);
        slot = 1'b1; bit_out(1'b1); slot = 1'b0;
    endtask

    task automatic read_byte(input string name, input logic [7:0] v, input logic ack);
        exp_nm.push_back(name); exp_val.push_back(v); exp_nb.push_back(8);
        slot = 1'b1;
        for (int i = 0; i < 8; i++) bit_out(1'b1);
        slot = 1'b0;
        bit_out(ack);
    endtask

    initial begin
        wait_clk(5);
        chk("rst_oe", SEL_OE, 1'b0);
        chk("rst_busy", SEL_BUSY, 1'b0);
        rst = 1'b0;
        wait_clk(5);

        // 1: byte write then random read
        i2c_start();
        write_byte("t1_dev_ack", 8'hA0, 1'b0);
        chk("t1_busy_up", SEL_BUSY, 1'b1);
        write_byte("t1_word_ack", 8'h10, 1'b0);
        write_byte("t1_data_ack", 8'hA5, 1'b0);
        i2c_stop();
        chk("t1_busy_stop", SEL_BUSY, 1'b0);
        i2c_start();
        write_byte("t1_rr_dev", 8'hA0, 1'b0);
        write_byte("t1_rr_word", 8'h10, 1'b0);
        i2c_start();
        write_byte("t1_rr_rdev", 8'hA1, 1'b0);
        read_byte("t1_rd_10", 8'hA5, 1'b1);
        chk("t1_busy_nack", SEL_BUSY, 1'b0);
        i2c_stop();

        // 2: foreign address is NACKed, then a normal write
        i2c_start();
        write_byte("t2_nack", 8'hA2, 1'b1);
        chk("t2_busy_low", SEL_BUSY, 1'b0);
        i2c_stop();
        i2c_start();
        write_byte("t2_dev_ok", 8'hA0, 1'b0);
        write_byte("t2_word", 8'h20, 1'b0);
        write_byte("t2_data", 8'h5A, 1'b0);
        i2c_stop();

        // 3: page write wrapping 0x0F -> 0x00
        i2c_start();
        write_byte("t3_dev", 8'hA0, 1'b0);
        write_byte("t3_word", 8'h0E, 1'b0);
        write_byte("t3_d0", 8'h11, 1'b0);
        write_byte("t3_d1", 8'h22, 1'b0);
        write_byte("t3_d2", 8'h33, 1'b0);
        write_byte("t3_d3", 8'h44, 1'b0);
        i2c_stop();
        i2c_start();
        write_byte("t3_rdev_w", 8'hA0, 1'b0);
        write_byte("t3_rword0e", 8'h0E, 1'b0);
        i2c_start();
        write_byte("t3_rdev_r", 8'hA1, 1'b0);
        read_byte("t3_rd_0e", 8'h11, 1'b0);
        read_byte("t3_rd_0f", 8'h22, 1'b0);
        read_byte("t3_rd_10", 8'hA5, 1'b1);
        i2c_stop();
        i2c_start();
        write_byte("t3_rdev_w2", 8'hA0, 1'b0);
        write_byte("t3_rword00", 8'h00, 1'b0);
        i2c_start();
        write_byte("t3_rdev_r2", 8'hA1, 1'b0);
        read_byte("t3_rd_00", 8'h33, 1'b0);
        read_byte("t3_rd_01", 8'h44, 1'b1);
        i2c_stop();

        // 4: top-of-memory write, sequential read wrapping 0xFF -> 0x00
        i2c_start();
        write_byte("t4_dev", 8'hA0, 1'b0);
        write_byte("t4_word", 8'hFD, 1'b0);
        write_byte("t4_d0", 8'hFF, 1'b0);
        write_byte("t4_d1", 8'h00, 1'b0);
        write_byte("t4_d2", 8'h7E, 1'b0);
        i2c_stop();
        i2c_start();
        write_byte("t4_rdev_w", 8'hA0, 1'b0);
        write_byte("t4_rword", 8'hFD, 1'b0);
        i2c_start();
        write_byte("t4_rdev_r", 8'hA1, 1'b0);
        read_byte("t4_rd_fd", 8'hFF, 1'b0);
        read_byte("t4_rd_fe", 8'h00, 1'b0);
        read_byte("t4_rd_ff", 8'h7E, 1'b0);
        read_byte("t4_rd_wrap", 8'h33, 1'b1);
        i2c_stop();

        // 5: STOP inside a data byte discards it
        i2c_start();
        write_byte("t5_dev", 8'hA0, 1'b0);
        write_byte("t5_word", 8'h20, 1'b0);
        for (int i = 0; i < 4; i++) bit_out(1'b1);
        i2c_stop();
        chk("t5_oe_idle", SEL_OE, 1'b0);
        chk("t5_busy_idle", SEL_BUSY, 1'b0);
        i2c_start();
        write_byte("t5_cur_dev", 8'hA1, 1'b0);
        read_byte("t5_cur_rd", 8'h5A, 1'b1);
        i2c_stop();

        // 6: reset while the slave drives a 0 data bit (0x5A has MSB 0)
        i2c_start();
        write_byte("t6_dev_w", 8'hA0, 1'b0);
        write_byte("t6_word", 8'h20, 1'b0);
        i2c_start();
        write_byte("t6_dev_r", 8'hA1, 1'b0);
        wait_clk(Q / 2);
        chk("t6_drive0", SEL_OE, 1'b1);
        chk("t6_busy_pre", SEL_BUSY, 1'b1);
        rst = 1'b1;
        #1;
        chk("t6_oe_rst", SEL_OE, 1'b0);
        chk("t6_busy_rst", SEL_BUSY, 1'b0);
        wait_clk(3);
        rst = 1'b0;
        wait_clk(Q);
        sda_m = 1'b1;
        scl_m = 1'b1;
        wait_clk(2 * Q);
        i2c_start();
        write_byte("t6_dev_after", 8'hA0, 1'b0);
        chk("t6_busy_after", SEL_BUSY, 1'b1);
        i2c_stop();
        chk("t6_busy_end", SEL_BUSY, 1'b0);

        wait_clk(20);
        done    = 1'b1;
        chk_tgl = ~chk_tgl;
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
